pipeline_hazard_ctrl: RTL and testbench

// Per-stage stall/flush controller for an N-stage in-order pipeline.

---
 rtl/pipeline_hazard_ctrl_if.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline units (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5
);
    logic [NUM_STAGES-1:0] stall_req_i;
    logic [NUM_STAGES-1:0] stage_valid_i;
    logic                  bru_miss_i;
    logic                  exception_flush_i;
    logic                  irq_req_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic                  irq_ack_o;
    logic                  redirect_busy_o;
    logic                  stall_timeout_o;
    logic [1:0]            state_o;

    modport master (
        output stall_req_i, stage_valid_i, bru_miss_i, exception_flush_i, irq_req_i,
        input  stall_o, flush_o, irq_ack_o, redirect_busy_o, stall_timeout_o, state_o
    );

    modport slave (
        input  stall_req_i, stage_valid_i, bru_miss_i, exception_flush_i, irq_req_i,
        output stall_o, flush_o, irq_ack_o, redirect_busy_o, stall_timeout_o, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush controller with redirect hold, interrupt drain handshake and stall watchdog.
//   state    | meaning
//   ST_RUN   | normal operation, stall/flush straight from requests
//   ST_HOLD  | redirect in progress, fetch (stage 0) kept flushed
//   ST_DRAIN | fetch stalled until younger stages empty, then irq_ack_o
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int BRU_STAGE    = 2,
    parameter int EXC_STAGE    = 3,
    parameter int REDIRECT_CYC = 2,
    parameter int WDOG_W       = 10
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int CNT_W = (REDIRECT_CYC > 1) ? $clog2(REDIRECT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REDIRECT_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  timeout_q;

    logic                  flush_evt;
    logic                  drained;
    logic [NUM_STAGES-1:0] base_stall;
    logic [NUM_STAGES-1:0] fmask;
    logic [NUM_STAGES-1:0] flush;
    logic [NUM_STAGES-1:0] stall;

    assign flush_evt = bus.bru_miss_i | bus.exception_flush_i;
    assign drained   = (bus.stage_valid_i[NUM_STAGES-1:1] == '0);

    // A stalled stage blocks every older (lower-index) stage behind it.
    always_comb begin
        base_stall = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            base_stall[k] = |(bus.stall_req_i >> k);
        end
    end

    always_comb begin
        fmask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (bus.exception_flush_i && (k <= EXC_STAGE)) fmask[k] = 1'b1;
            if (bus.bru_miss_i && (k < BRU_STAGE))         fmask[k] = 1'b1;
        end
    end

    always_comb begin
        flush = fmask;
        if (state_q == ST_HOLD) flush[0] = 1'b1;
        stall = base_stall & ~flush;
        if ((state_q == ST_DRAIN) && !flush[0]) stall[0] = 1'b1;
    end

    // Re-entry to DRAIN is blocked while the ack is visible, since the requester drops irq only after seeing it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_evt) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_LOAD;
                end else if (bus.irq_req_i && !ack_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (flush_evt) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = bus.irq_req_i ? ST_DRAIN : ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (flush_evt) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_LOAD;
                end else if (!bus.irq_req_i) begin
                    state_d = ST_RUN;
                end else if (drained) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wdog_d = wdog_q;
        if (flush_evt || !(|base_stall)) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q | (wdog_d == '1);
        end
    end

    assign bus.stall_o         = stall;
    assign bus.flush_o         = flush;
    assign bus.irq_ack_o       = ack_q;
    assign bus.redirect_busy_o = (state_q == ST_HOLD);
    assign bus.stall_timeout_o = timeout_q;
    assign bus.state_o         = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipeline_hazard_ctrl;
    localparam int NS           = 5;
    localparam int BRU_STAGE    = 2;
    localparam int EXC_STAGE    = 3;
    localparam int REDIRECT_CYC = 2;
    localparam int WDOG_W       = 4;
    localparam int WDOG_MAX     = (1 << WDOG_W) - 1;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   failures = 0;

    // model: mode 0 run, 1 redirect hold, 2 drain
    int   m_mode, m_hold_left, m_wdog;
    logic m_ack, m_timeout;

    pipeline_hazard_ctrl_if #(.NUM_STAGES(NS)) bus ();

    pipeline_hazard_ctrl #(
        .NUM_STAGES(NS), .BRU_STAGE(BRU_STAGE), .EXC_STAGE(EXC_STAGE),
        .REDIRECT_CYC(REDIRECT_CYC), .WDOG_W(WDOG_W)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [NS-1:0] exp_flush(logic exc, logic bru, int mode);
        int v;
        v = 0;
        if (exc) v = v | ((1 << (EXC_STAGE + 1)) - 1);
        if (bru) v = v | ((1 << BRU_STAGE) - 1);
        if (mode == 1) v = v | 1;
        return NS'(v);
    endfunction

    function automatic logic [NS-1:0] exp_stall(logic [NS-1:0] req, logic [NS-1:0] fl, int mode);
        logic [NS-1:0] s;
        s = '0;
        for (int k = 0; k < NS; k++) begin
            if (((req >> k) != 0) && !fl[k]) s[k] = 1'b1;
        end
        if (mode == 2 && !fl[0]) s[0] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold_left = 0; m_wdog = 0; m_ack = 1'b0; m_timeout = 1'b0;
    endtask

    task automatic model_advance();
        logic fl;
        logic nack;
        fl   = bus.bru_miss_i | bus.exception_flush_i;
        nack = 1'b0;
        case (m_mode)
            0: begin
                if (fl) begin m_mode = 1; m_hold_left = REDIRECT_CYC; end
                else if (bus.irq_req_i && !m_ack) m_mode = 2;
            end
            1: begin
                if (fl) m_hold_left = REDIRECT_CYC;
                else begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_mode = bus.irq_req_i ? 2 : 0;
                end
            end
            default: begin
                if (fl) begin m_mode = 1; m_hold_left = REDIRECT_CYC; end
                else if (!bus.irq_req_i) m_mode = 0;
                else if (bus.stage_valid_i[NS-1:1] == 0) begin nack = 1'b1; m_mode = 0; end
            end
        endcase
        if (fl || bus.stall_req_i == 0) m_wdog = 0;
        else if (m_wdog < WDOG_MAX) m_wdog++;
        if (m_wdog == WDOG_MAX) m_timeout = 1'b1;
        m_ack = nack;
    endtask

    task automatic drive(logic [NS-1:0] req, logic [NS-1:0] valid, logic bru, logic exc, logic irq);
        bus.stall_req_i = req; bus.stage_valid_i = valid;
        bus.bru_miss_i = bru; bus.exception_flush_i = exc; bus.irq_req_i = irq;
    endtask

    task automatic tick();
        if (rst_ni) model_advance(); else model_reset();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk_i); #1;
        checks++;
        if (bus.state_o !== 2'd0 || bus.irq_ack_o !== 1'b0 || bus.stall_timeout_o !== 1'b0) begin
            failures++; $display("FAIL reset_values: state=%0d ack=%b timeout=%b required 0 0 0",
                                 bus.state_o, bus.irq_ack_o, bus.stall_timeout_o);
        end
        rst_ni = 1'b1;
        drive('0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.state_o !== 2'd1) begin
            failures++; $display("FAIL reset_enter_hold: state=%0d required 1", bus.state_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (bus.state_o !== 2'd0 || bus.irq_ack_o !== 1'b0 || bus.stall_timeout_o !== 1'b0 ||
            bus.redirect_busy_o !== 1'b0 || bus.flush_o !== 5'b00000) begin
            failures++; $display("FAIL reset_async_mid_hold: state=%0d busy=%b flush=%b required 0 0 00000",
                                 bus.state_o, bus.redirect_busy_o, bus.flush_o);
        end
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_stall();
        logic [NS-1:0] reqs[3] = '{5'b01000, 5'b00001, 5'b10100};
        logic [NS-1:0] exps[3] = '{5'b01111, 5'b00001, 5'b11111};
        for (int i = 0; i < 3; i++) begin
            drive(reqs[i], '0, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (bus.stall_o !== exps[i] || bus.flush_o !== 5'b00000) begin
                failures++; $display("FAIL stall_prop[%0d]: stall=%b flush=%b required %b 00000",
                                     i, bus.stall_o, bus.flush_o, exps[i]);
            end
            tick();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch_miss();
        drive(5'b10000, '0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.flush_o !== 5'b00011 || bus.stall_o !== 5'b11100) begin
            failures++; $display("FAIL bru_flush: flush=%b stall=%b required 00011 11100", bus.flush_o, bus.stall_o);
        end
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < REDIRECT_CYC; i++) begin
            #1;
            checks++;
            if (bus.flush_o !== 5'b00001 || bus.redirect_busy_o !== 1'b1) begin
                failures++; $display("FAIL bru_hold[%0d]: flush=%b busy=%b required 00001 1",
                                     i, bus.flush_o, bus.redirect_busy_o);
            end
            tick();
        end
        checks++;
        if (bus.state_o !== 2'd0 || bus.redirect_busy_o !== 1'b0 || bus.flush_o !== 5'b00000) begin
            failures++; $display("FAIL bru_back_to_run: state=%0d busy=%b flush=%b required 0 0 00000",
                                 bus.state_o, bus.redirect_busy_o, bus.flush_o);
        end
    endtask

    task automatic test_exc_bru_and_reload();
        drive('0, '0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.flush_o !== 5'b01111) begin
            failures++; $display("FAIL exc_bru_union: flush=%b required 01111", bus.flush_o);
        end
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.state_o !== 2'd1 || bus.flush_o !== 5'b01111) begin
            failures++; $display("FAIL exc_in_hold_last: state=%0d flush=%b required 1 01111", bus.state_o, bus.flush_o);
        end
        tick();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < REDIRECT_CYC; i++) begin
            checks++;
            if (bus.state_o !== 2'd1) begin
                failures++; $display("FAIL hold_reload[%0d]: state=%0d required 1", i, bus.state_o);
            end
            tick();
        end
        checks++;
        if (bus.state_o !== 2'd0) begin
            failures++; $display("FAIL hold_reload_exit: state=%0d required 0", bus.state_o);
        end
    endtask

    task automatic test_irq_drain();
        logic [NS-1:0] seq[5] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
        int acks = 0;
        drive('0, 5'b11110, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.stage_valid_i = seq[i];
            #1;
            checks++;
            if (bus.state_o !== 2'd2 || bus.stall_o[0] !== 1'b1 || bus.irq_ack_o !== 1'b0) begin
                failures++; $display("FAIL drain[%0d]: state=%0d stall0=%b ack=%b required 2 1 0",
                                     i, bus.state_o, bus.stall_o[0], bus.irq_ack_o);
            end
            tick();
        end
        if (bus.irq_ack_o === 1'b1) acks++;
        checks++;
        if (bus.irq_ack_o !== 1'b1 || bus.state_o !== 2'd0) begin
            failures++; $display("FAIL drain_ack: ack=%b state=%0d required 1 0", bus.irq_ack_o, bus.state_o);
        end
        bus.irq_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.irq_ack_o === 1'b1) acks++;
        end
        checks++;
        if (acks != 1 || bus.state_o !== 2'd0) begin
            failures++; $display("FAIL drain_ack_count: acks=%0d state=%0d required 1 0", acks, bus.state_o);
        end
    endtask

    task automatic test_irq_exc();
        int acks = 0;
        drive('0, 5'b11110, 1'b0, 1'b0, 1'b1);
        tick();
        bus.exception_flush_i = 1'b1;
        #1;
        checks++;
        if (bus.state_o !== 2'd2 || bus.flush_o !== 5'b01111 || bus.stall_o[0] !== 1'b0) begin
            failures++; $display("FAIL drain_exc: state=%0d flush=%b stall0=%b required 2 01111 0",
                                 bus.state_o, bus.flush_o, bus.stall_o[0]);
        end
        tick();
        bus.exception_flush_i = 1'b0;
        for (int i = 0; i < REDIRECT_CYC; i++) begin
            checks++;
            if (bus.state_o !== 2'd1 || bus.redirect_busy_o !== 1'b1) begin
                failures++; $display("FAIL drain_exc_hold[%0d]: state=%0d busy=%b required 1 1",
                                     i, bus.state_o, bus.redirect_busy_o);
            end
            tick();
        end
        checks++;
        if (bus.state_o !== 2'd2) begin
            failures++; $display("FAIL drain_reenter: state=%0d required 2", bus.state_o);
        end
        bus.stage_valid_i = '0;
        tick();
        if (bus.irq_ack_o === 1'b1) acks++;
        bus.irq_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.irq_ack_o === 1'b1) acks++;
        end
        checks++;
        if (acks != 1 || bus.state_o !== 2'd0) begin
            failures++; $display("FAIL drain_exc_ack_count: acks=%0d state=%0d required 1 0", acks, bus.state_o);
        end
    endtask

    task automatic test_watchdog();
        drive(5'b10000, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.stall_o !== 5'b11111) begin
            failures++; $display("FAIL wdog_stall: stall=%b required 11111", bus.stall_o);
        end
        for (int i = 1; i <= WDOG_MAX; i++) begin
            tick();
            checks++;
            if (bus.stall_timeout_o !== (i >= WDOG_MAX)) begin
                failures++; $display("FAIL wdog_cycle[%0d]: timeout=%b required %b",
                                     i, bus.stall_timeout_o, (i >= WDOG_MAX));
            end
        end
        bus.stall_req_i = '0;
        tick();
        bus.bru_miss_i = 1'b1;
        tick();
        bus.bru_miss_i = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus.stall_timeout_o !== 1'b1 || bus.state_o !== 2'd0) begin
            failures++; $display("FAIL wdog_sticky: timeout=%b state=%0d required 1 0", bus.stall_timeout_o, bus.state_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (bus.stall_timeout_o !== 1'b0) begin
            failures++; $display("FAIL wdog_reset_clear: timeout=%b required 0", bus.stall_timeout_o);
        end
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        logic [NS-1:0] ef, es;
        logic irq;
        irq = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (irq && m_ack) irq = 1'b0;
            else if (irq) irq = ($urandom_range(0, 19) != 0);
            else irq = ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 2) == 0) ? NS'($urandom) : '0,
                  ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 13) == 0), irq);
            #1;
            ef = exp_flush(bus.exception_flush_i, bus.bru_miss_i, m_mode);
            es = exp_stall(bus.stall_req_i, ef, m_mode);
            checks++;
            if (bus.flush_o !== ef) begin
                failures++; $display("FAIL rand_flush[%0d]: got %b required %b", c, bus.flush_o, ef);
            end
            checks++;
            if (bus.stall_o !== es) begin
                failures++; $display("FAIL rand_stall[%0d]: got %b required %b", c, bus.stall_o, es);
            end
            checks++;
            if (bus.state_o !== 2'(m_mode) || bus.redirect_busy_o !== (m_mode == 1)) begin
                failures++; $display("FAIL rand_state[%0d]: state=%0d busy=%b required %0d", c,
                                     bus.state_o, bus.redirect_busy_o, m_mode);
            end
            checks++;
            if (bus.irq_ack_o !== m_ack || bus.stall_timeout_o !== m_timeout) begin
                failures++; $display("FAIL rand_regs[%0d]: ack=%b timeout=%b required %b %b", c,
                                     bus.irq_ack_o, bus.stall_timeout_o, m_ack, m_timeout);
            end
            tick();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_miss();
        test_exc_bru_and_reload();
        test_irq_drain();
        test_irq_exc();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
